// File: rtl/locker_pkg.sv
// Shared state type and width helpers for the serial password locker.
package locker_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_UNLOCK  = 3'd2,
        ST_ERROR   = 3'd3,
        ST_LOCKOUT = 3'd4,
        ST_PROGRAM = 3'd5
    } locker_state_t;

    function automatic int unsigned tries_width(input int unsigned max_tries);
        return (max_tries < 2) ? 1 : $clog2(max_tries + 1);
    endfunction

    function automatic int unsigned count_width(input int unsigned pwd_len);
        return (pwd_len < 2) ? 1 : $clog2(pwd_len + 1);
    endfunction

    function automatic int unsigned timer_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/serial_pwd_shifter.sv
// MSB-first serial capture register with a bit counter that wraps when a word completes.
module serial_pwd_shifter
    import locker_pkg::*;
#(
    parameter int unsigned PWD_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_clear,
    input  logic               i_shift,
    input  logic               i_bit,
    output logic [PWD_LEN-1:0] o_next_word,
    output logic               o_done
);

    localparam int unsigned CW = count_width(PWD_LEN);

    logic [PWD_LEN-1:0] r_word;
    logic [CW-1:0]      r_bit_cnt;
    logic               w_last;

    assign w_last      = (r_bit_cnt == CW'(PWD_LEN - 1));
    // Word as it will be after this shift, so the compare lands on the capturing edge.
    assign o_next_word = (r_word << 1) | PWD_LEN'(i_bit);
    assign o_done      = i_shift & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word    <= '0;
            r_bit_cnt <= '0;
        end else if (i_clear) begin
            r_word    <= '0;
            r_bit_cnt <= '0;
        end else if (i_shift) begin
            r_word    <= o_next_word;
            r_bit_cnt <= w_last ? '0 : r_bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_locker_ctrl.sv
// Serial password locker: entry/compare FSM, programmable password, retry count and timed lockout.
module serial_locker_ctrl
    import locker_pkg::*;
#(
    parameter int unsigned        PWD_LEN        = 4,
    parameter logic [PWD_LEN-1:0] DEFAULT_PWD    = 4'b1100,
    parameter int unsigned        MAX_TRIES      = 3,
    parameter int unsigned        LOCKOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              bit_valid,
    input  logic                              pwd_in,
    input  logic                              submit,
    input  logic                              prog_en,
    output logic                              locked,
    output logic                              unlocked,
    output logic                              error,
    output logic                              lockout,
    output logic                              prog_active,
    output logic [tries_width(MAX_TRIES)-1:0] tries_left
);

    localparam int unsigned TW = tries_width(MAX_TRIES);
    localparam int unsigned LW = timer_width(LOCKOUT_CYCLES);

    locker_state_t      r_state, w_state_nxt;
    logic [PWD_LEN-1:0] r_stored_pwd, w_pwd_nxt;
    logic [TW-1:0]      r_fail_cnt, w_fail_nxt, w_fail_inc;
    logic [LW-1:0]      r_timer, w_timer_nxt;
    logic               w_clear, w_shift, w_done;
    logic [PWD_LEN-1:0] w_next_word;

    serial_pwd_shifter #(
        .PWD_LEN (PWD_LEN)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_clear),
        .i_shift     (w_shift),
        .i_bit       (pwd_in),
        .o_next_word (w_next_word),
        .o_done      (w_done)
    );

    assign w_fail_inc = (r_fail_cnt >= TW'(MAX_TRIES)) ? TW'(MAX_TRIES) : r_fail_cnt + TW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_stored_pwd <= DEFAULT_PWD;
            r_fail_cnt   <= '0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_stored_pwd <= w_pwd_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_timer      <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pwd_nxt   = r_stored_pwd;
        w_fail_nxt  = r_fail_cnt;
        w_timer_nxt = r_timer;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bit_valid) begin
                    w_shift     = 1'b1;
                    w_state_nxt = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (submit) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (bit_valid) begin
                    w_shift = 1'b1;
                    if (w_done) begin
                        if (w_next_word == r_stored_pwd) begin
                            w_state_nxt = ST_UNLOCK;
                            w_fail_nxt  = '0;
                        end else begin
                            w_fail_nxt = w_fail_inc;
                            if (w_fail_inc == TW'(MAX_TRIES)) begin
                                w_state_nxt = ST_LOCKOUT;
                                w_timer_nxt = LW'(LOCKOUT_CYCLES - 1);
                            end else begin
                                w_state_nxt = ST_ERROR;
                            end
                        end
                    end
                end
            end
            ST_UNLOCK: begin
                if (submit) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (prog_en) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_PROGRAM;
                end
            end
            ST_PROGRAM: begin
                if (submit) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_UNLOCK;
                end else if (bit_valid) begin
                    w_shift = 1'b1;
                    if (w_done) begin
                        w_pwd_nxt   = w_next_word;
                        w_state_nxt = ST_UNLOCK;
                    end
                end
            end
            ST_ERROR: begin
                if (submit) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_fail_nxt  = '0;
                end else begin
                    w_timer_nxt = r_timer - LW'(1);
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign locked      = (r_state != ST_UNLOCK) && (r_state != ST_PROGRAM);
    assign unlocked    = (r_state == ST_UNLOCK) || (r_state == ST_PROGRAM);
    assign error       = (r_state == ST_ERROR);
    assign lockout     = (r_state == ST_LOCKOUT);
    assign prog_active = (r_state == ST_PROGRAM);
    assign tries_left  = TW'(MAX_TRIES) - r_fail_cnt;

endmodule

// File: doc/serial_locker_ctrl.md
# serial_locker_ctrl

Parametrised serial-password lock controller, the next generation of the team's digital locker FSM. It collects a PWD_LEN-bit password one qualified bit at a time and compares the whole word against a stored, field-programmable password. It counts consecutive failures and enforces a timed lockout after MAX_TRIES. It sits between the keypad/serial front end and the actuator driver, and exposes Moore-decoded status outputs.

## Interface
- PWD_LEN, 4: password length in bits; legal range 2..32.
- DEFAULT_PWD, 4'b1100: password loaded at reset (PWD_LEN bits wide).
- MAX_TRIES, 3: consecutive failed entries before lockout; minimum 1.
- LOCKOUT_CYCLES, 16: clock cycles spent in lockout; minimum 1.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- bit_valid  in  1  qualifies pwd_in for the current cycle.
- pwd_in  in  1  serial password bit, sent MSB first.
- submit  in  1  in UNLOCK, relocks; in ERROR, clears; in ENTRY/PROGRAM, aborts.
- prog_en  in  1  request to reprogram the password; honoured only in UNLOCK.
- locked  out  1  high in every state except UNLOCK and PROGRAM.
- unlocked  out  1  high in UNLOCK and PROGRAM.
- error  out  1  high in ERROR.
- lockout  out  1  high in LOCKOUT.
- prog_active  out  1  high in PROGRAM.
- tries_left  out  $clog2(MAX_TRIES+1)  equals MAX_TRIES minus fail_cnt.

## Operation
- States: IDLE, ENTRY, UNLOCK, ERROR, LOCKOUT, PROGRAM.
- Outputs are decoded from the state register only, with no input-to-output paths.
- Bit capture: a shift register loads on each rising edge with bit_valid=1, using shift-left with pwd_in as the LSB. A counter bit_cnt tracks the number of captured bits.
- IDLE:
  - bit_valid: capture the bit, set bit_cnt=1, go to ENTRY.
  - submit alone: ignored.
- ENTRY:
  - On the edge that captures the PWD_LEN-th bit, compare the full word against stored_pwd.
  - On a match: go to UNLOCK and clear fail_cnt.
  - On a mismatch: increment fail_cnt. If the new value equals MAX_TRIES, go to LOCKOUT; otherwise go to ERROR.
  - Mismatches are not flagged early, so the position of a wrong bit is never leaked.
- UNLOCK:
  - submit: go to IDLE.
  - prog_en (with submit=0): go to PROGRAM and clear bit_cnt.
- PROGRAM:
  - Capture PWD_LEN bits. On the final bit, write the word to stored_pwd and return to UNLOCK.
  - submit: abort to UNLOCK with stored_pwd unchanged.
- ERROR:
  - submit: go to IDLE and clear bit_cnt.
  - bit_valid: ignored.
- LOCKOUT:
  - On entry, load the timer with LOCKOUT_CYCLES-1, then decrement it every cycle.
  - When the timer reaches 0, go to IDLE and clear fail_cnt.
  - All inputs are ignored.
- Simultaneous events:
  - submit wins over bit_valid in ENTRY and PROGRAM: abort, and the bit is discarded.
  - submit wins over prog_en in UNLOCK.
  - An aborted ENTRY does not change fail_cnt.
- Width rules: fail_cnt saturates at MAX_TRIES. The timer is $clog2(LOCKOUT_CYCLES) bits wide, with a minimum of 1.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- Reset asserted, at any time including mid-entry or mid-program, immediately sets:
  - state to IDLE, stored_pwd to DEFAULT_PWD, fail_cnt to 0, bit_cnt to 0, timer to 0.
  - locked=1; unlocked, error, lockout, prog_active all 0.
  - tries_left to MAX_TRIES.
- A programmed password is not retained across reset.
- Entry latency: the status outputs reflect the compare result from the edge that captures the last bit, i.e. zero cycles after the final bit_valid edge.
- Back-to-back bit_valid on every cycle is supported, giving PWD_LEN cycles per entry.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles; lockout=1 for that many consecutive samples.
- A submit relock in UNLOCK drops unlocked after one edge.

## Structure
- Package locker_pkg contains:
  - the state enum typedef locker_state_t;
  - a helper function computing the tries_left width.
- Sub-module serial_pwd_shifter: PWD_LEN-bit shift register plus bit_cnt, with clear/shift inputs and a done flag. It is shared by ENTRY and PROGRAM.
- The top level holds the FSM, stored_pwd, fail_cnt and the lockout timer.

## Test plan
- Default params, bits 1,1,0,0 with bit_valid -> unlocked=1 and locked=0 from the 4th edge; tries_left=3; submit -> locked=1 next edge.
- Bits 1,0,1,0 -> error=1 and tries_left=2; bits during ERROR are ignored; submit -> IDLE.
- Three wrong entries -> lockout=1 for exactly 16 cycles, inputs ignored, then IDLE with tries_left=3.
- Unlock, prog_en, bits 0,1,1,0 -> back to UNLOCK. Then relock: 1,1,0,0 fails and 0,1,1,0 unlocks. Then reset: 1,1,0,0 unlocks again.
- submit together with bit_valid after 2 bits -> IDLE, tries_left unchanged. A following correct entry unlocks.
- PWD_LEN=8, DEFAULT_PWD=8'hA5 with rst_n pulsed low mid-entry -> all outputs at reset values; a full 8'hA5 entry afterwards unlocks.
